unidade_processamento_seq: RTL and testbench
============================================

# unidade_processamento_seq

Parametrised, self-sequenced accumulator datapath: one synchronous-read data memory, an ALU, an accumulator and N/Z/C/V flag registers, driven by an internal state machine. It accepts one operation per start/done handshake and replaces externally driven per-cycle control strobes (memory write, accumulator write, flag write). It sits between the future control unit, which issues `op`/`addr`, and the memory, and carries the system's accumulator state.

## Interface
- `WIDTH`, 16, data/accumulator width (≥4)
- `ADDR_W`, 8, memory address width; depth = 2**ADDR_W words
---
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  operation request; sampled only in IDLE
- `op`  in  3  operation code, latched on accept
- `addr`  in  ADDR_W  operand address, latched on accept
- `ext_we`  in  1  memory preload strobe (IDLE only)
- `ext_addr`  in  ADDR_W  preload address
- `ext_data`  in  WIDTH  preload data
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle completion pulse
- `q_AC`  out  WIDTH  accumulator
- `q_MEM`  out  WIDTH  registered memory read data
- `q_N`, `q_Z`, `q_C`, `q_V`  out  1 each  flag registers

## Operation
- Op codes: 000 LDA (AC←M), 001 ADD (AC←AC+M), 010 SUB (AC←AC−M), 011 AND, 100 OR, 101 NOT (AC←~AC, no memory read used), 110 STA (M←AC), 111 NOP.
- States: IDLE, READ, EXEC, WRITE.
- IDLE: `start`=1 latches `op`/`addr`; op 000–101 → READ; 110 → WRITE; 111 → IDLE with `done` next cycle.
- READ: memory addressed with latched `addr`; `q_MEM` registers M[addr] at end of cycle → EXEC.
- EXEC: ALU result written to AC, flags written at end of cycle → IDLE.
- WRITE: memory written with AC at latched address at end of cycle → IDLE; AC and flags unchanged.
- Flags updated only in EXEC: N = result MSB; Z = (result == 0); ADD: C = carry out, V = signed overflow; SUB: C = borrow (AC < M unsigned), V = signed overflow; LDA/AND/OR/NOT: C = 0, V = 0.
- All arithmetic modulo 2**WIDTH.
- `start` while busy: ignored, no queueing.
- `ext_we` honoured only in IDLE with `start`=0; otherwise dropped. When honoured, writes `ext_data` to M[`ext_addr`] at that edge.
- Memory contents are not reset. `q_MEM` holds its last value outside READ.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `q_AC`=0, `q_MEM`=0, all flags 0.
- Start accepted in cycle 0 (IDLE, `start`=1).
- ALU ops: READ cycle 1, EXEC cycle 2, `done`=1 in cycle 3. New-value AC/flags are visible from cycle 3.
- STA: WRITE cycle 1, `done`=1 in cycle 2. A READ of the same address started in cycle 2 returns the new value.
- NOP: `done`=1 in cycle 1.
- `done` coincides with IDLE, so a new `start` is accepted in the `done` cycle. Back-to-back ALU ops therefore take one op per 3 cycles.
- `rst_n` low in any state: immediate return to IDLE with reset values. A WRITE in progress is aborted and memory is not written on that edge. `done` is not issued for the aborted op.

## Structure
- Shared package `up_pkg`: op-code constants, state enum, default `WIDTH`/`ADDR_W`.
- One sub-module: `ula_param` (combinational, parameter `WIDTH`; inputs X, Y, op; outputs result, N, Z, C, V).
- Memory is inferred in the block as a single-port synchronous array with the preload mux on its write port. Accumulator and flags are plain registers.

## Test plan
- Reset mid-EXEC: assert `rst_n`=0 during EXEC → AC=0, flags 0, `busy`=0, no `done` pulse.
- Preload M[3]=0x7FFF, M[4]=0x0001; LDA 3, ADD 4 → AC=0x8000, N=1, Z=0, C=0, V=1; each `done` exactly 3 cycles after start.
- AC=0x0002, M[5]=0x0003; SUB 5 → AC=0xFFFF, N=1, C=1, V=0. Then SUB 5 with AC=0x0003 → AC=0, Z=1, C=0.
- STA 9 with AC=0x1234, then LDA 9 started in the `done` cycle → `q_MEM`=0x1234, AC=0x1234; STA `done` at cycle 2.
- `start` and `ext_we` pulsed while busy → both ignored. Memory, AC and op sequence are unchanged; exactly one `done` is produced.
- NOT on AC=0xFFFF → AC=0, Z=1, C=V=0. NOP → `done` in cycle 1, flags and AC untouched.

Source files
------------

// File: rtl/up_pkg.sv
// Shared definitions for the self-sequenced accumulator datapath:
// default sizes, operation codes and the sequencer state encoding.
package up_pkg;

  localparam int UP_WIDTH  = 16;
  localparam int UP_ADDR_W = 8;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,  // AC <- M
    OP_ADD = 3'b001,  // AC <- AC + M
    OP_SUB = 3'b010,  // AC <- AC - M
    OP_AND = 3'b011,  // AC <- AC & M
    OP_OR  = 3'b100,  // AC <- AC | M
    OP_NOT = 3'b101,  // AC <- ~AC
    OP_STA = 3'b110,  // M  <- AC
    OP_NOP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage : up_pkg

// File: rtl/ula_param.sv
// Combinational ALU: X is the accumulator, Y the memory operand.
// Produces the result together with the N/Z/C/V flag values.
module ula_param
  import up_pkg::*;
#(
  parameter int WIDTH = UP_WIDTH
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  logic [WIDTH:0] wide;

  // Operation select; carry/borrow taken from the extra top bit of wide.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    wide   = '0;
    result = X;
    C      = 1'b0;
    V      = 1'b0;
    case (op)
      OP_LDA: result = Y;
      OP_ADD: begin
        wide   = {1'b0, X} + {1'b0, Y};
        result = wide[WIDTH-1:0];
        C      = wide[WIDTH];
        V      = (X[WIDTH-1] == Y[WIDTH-1]) && (result[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SUB: begin
        wide   = {1'b0, X} - {1'b0, Y};
        result = wide[WIDTH-1:0];
        C      = wide[WIDTH];  // borrow: X < Y unsigned
        V      = (X[WIDTH-1] != Y[WIDTH-1]) && (result[WIDTH-1] != X[WIDTH-1]);
      end
      OP_AND:  result = X & Y;
      OP_OR:   result = X | Y;
      OP_NOT:  result = ~X;
      default: result = X;  // STA/NOP never reach EXEC
    endcase
    N = result[WIDTH-1];
    Z = (result == '0);
  end

endmodule : ula_param

// File: rtl/unidade_processamento_seq.sv
// Self-sequenced accumulator datapath: one start/done handshake per
// operation, internal READ/EXEC/WRITE sequencing, synchronous data memory
// with an IDLE-only preload port, accumulator and N/Z/C/V flags.
module unidade_processamento_seq
  import up_pkg::*;
#(
  parameter int WIDTH  = UP_WIDTH,
  parameter int ADDR_W = UP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  q_AC,
  output logic [WIDTH-1:0]  q_MEM,
  output logic              q_N,
  output logic              q_Z,
  output logic              q_C,
  output logic              q_V
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic [WIDTH-1:0]  alu_result;
  logic              alu_n, alu_z, alu_c, alu_v;

  ula_param #(.WIDTH(WIDTH)) u_ula (
    .X      (q_AC),
    .Y      (q_MEM),
    .op     (op_q),
    .result (alu_result),
    .N      (alu_n),
    .Z      (alu_z),
    .C      (alu_c),
    .V      (alu_v)
  );

  // Memory write port: STA in WRITE, otherwise the preload path when idle.
  // Writes are blocked while reset is asserted so an aborted STA never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = q_AC;
    if (rst_n) begin
      if (state == S_WRITE) begin
        mem_we = 1'b1;
      end else if (state == S_IDLE && !start && ext_we) begin
        mem_we    = 1'b1;
        mem_waddr = ext_addr;
        mem_wdata = ext_data;
      end
    end
  end

  // Data memory storage.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose; a reset branch here would turn
    // the storage into a flop bank instead of an inferable RAM.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Sequencer with registered busy/done, operand latch, read register, AC and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_q   <= OP_NOP;
      addr_q <= '0;
      q_AC   <= '0;
      q_MEM  <= '0;
      q_N    <= 1'b0;
      q_Z    <= 1'b0;
      q_C    <= 1'b0;
      q_V    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_t'(op);
            addr_q <= addr;
            case (op_t'(op))
              OP_STA: begin
                state <= S_WRITE;
                busy  <= 1'b1;
              end
              OP_NOP: done <= 1'b1;
              default: begin
                state <= S_READ;
                busy  <= 1'b1;
              end
            endcase
          end
        end
        S_READ: begin
          q_MEM <= mem[addr_q];
          state <= S_EXEC;
        end
        S_EXEC: begin
          q_AC  <= alu_result;
          q_N   <= alu_n;
          q_Z   <= alu_z;
          q_C   <= alu_c;
          q_V   <= alu_v;
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_WRITE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : unidade_processamento_seq

// File: tb/tb_unidade_processamento_seq.sv
// Scoreboard bench for unidade_processamento_seq: each issued operation
// pushes its expected AC/flags/q_MEM/latency; the entry is popped and
// compared when done is observed.
module tb_unidade_processamento_seq;

  localparam logic [2:0] LDA = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011,
                         OR_ = 3'b100, NOT_ = 3'b101, STA = 3'b110, NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  addr;
  logic        ext_we;
  logic [7:0]  ext_addr;
  logic [15:0] ext_data;
  logic        busy, done;
  logic [15:0] q_AC, q_MEM;
  logic        q_N, q_Z, q_C, q_V;

  unidade_processamento_seq #(.WIDTH(16), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .addr     (addr),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_data (ext_data),
    .busy     (busy),
    .done     (done),
    .q_AC     (q_AC),
    .q_MEM    (q_MEM),
    .q_N      (q_N),
    .q_Z      (q_Z),
    .q_C      (q_C),
    .q_V      (q_V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ac;
    logic        n, z, c, v;
    logic [15:0] qm;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state
  logic [15:0] m_mem [256];
  logic [15:0] m_ac = 16'h0;
  logic [15:0] m_qm = 16'h0;
  logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

  task automatic model_op(input logic [2:0] o, input logic [7:0] a, output exp_t e);
    logic [15:0] m, r;
    int s, sa, sm;
    m  = m_mem[a];
    sa = $signed(m_ac);
    sm = $signed(m);
    r  = m_ac;
    case (o)
      LDA: begin r = m; m_c = 1'b0; m_v = 1'b0; end
      ADD: begin
        s = int'(m_ac) + int'(m);
        r = s[15:0];
        m_c = (s > 65535);
        m_v = ((sa + sm) > 32767) || ((sa + sm) < -32768);
      end
      SUB: begin
        s = int'(m_ac) - int'(m);
        r = s[15:0];
        m_c = (m_ac < m);
        m_v = ((sa - sm) > 32767) || ((sa - sm) < -32768);
      end
      AND_: begin r = m_ac & m; m_c = 1'b0; m_v = 1'b0; end
      OR_:  begin r = m_ac | m; m_c = 1'b0; m_v = 1'b0; end
      NOT_: begin r = ~m_ac;    m_c = 1'b0; m_v = 1'b0; end
      default: ;
    endcase
    if (o <= NOT_) begin
      m_ac = r;
      m_n  = r[15];
      m_z  = (r == 16'h0);
      m_qm = m;
    end
    if (o == STA) m_mem[a] = m_ac;
    e.ac = m_ac; e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v; e.qm = m_qm;
    e.lat = (o == NOP) ? 1 : (o == STA) ? 2 : 3;
  endtask

  // Preload one word through the external port while idle.
  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    @(posedge clk); #1;
    ext_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Issue one op in the current (idle) cycle and wait for its done pulse.
  // Returns at posedge+1 of the done cycle, so calls chain back-to-back.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input bit disturb);
    exp_t e;
    int   cyc;
    model_op(o, a, e);
    sb.push_back(e);
    start = 1'b1; op = o; addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 12) begin
      if (cyc == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_op%0d: busy=%b required 1", o, busy);
        end
      end
      if (disturb && (cyc == 1 || cyc == 2)) begin
        start = 1'b1; op = NOT_; addr = a + 8'd1;
        ext_we = 1'b1; ext_addr = a; ext_data = 16'h5555;
      end else begin
        start = 1'b0; ext_we = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; ext_we = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout_op%0d: no done within %0d cycles", o, cyc);
    end else if (cyc !== e.lat) begin
      miscompares++;
      $display("FAIL latency_op%0d: done at cycle %0d required %0d", o, cyc, e.lat);
    end
    vectors++;
    if ({q_AC, q_N, q_Z, q_C, q_V, q_MEM} !== {e.ac, e.n, e.z, e.c, e.v, e.qm}) begin
      miscompares++;
      $display("FAIL result_op%0d_addr%0d: AC=%h NZCV=%b%b%b%b MEM=%h required AC=%h NZCV=%b%b%b%b MEM=%h",
               o, a, q_AC, q_N, q_Z, q_C, q_V, q_MEM, e.ac, e.n, e.z, e.c, e.v, e.qm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = NOP; addr = 8'h0;
    ext_we = 1'b0; ext_addr = 8'h0; ext_data = 16'h0;
    #3;
    vectors++;
    if ({busy, done, q_AC, q_MEM, q_N, q_Z, q_C, q_V} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%b done=%b AC=%h MEM=%h NZCV=%b%b%b%b required all 0",
               busy, done, q_AC, q_MEM, q_N, q_Z, q_C, q_V);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, q_AC} !== 18'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b done=%b AC=%h required 0", busy, done, q_AC);
    end
  endtask

  task automatic test_add();
    preload(8'd3, 16'h7FFF);
    preload(8'd4, 16'h0001);
    run_op(LDA, 8'd3, 1'b0);
    run_op(ADD, 8'd4, 1'b0);
    vectors++;
    if ({q_AC, q_N, q_Z, q_C, q_V} !== {16'h8000, 4'b1001}) begin
      miscompares++;
      $display("FAIL add_overflow: AC=%h NZCV=%b%b%b%b required AC=8000 NZCV=1001",
               q_AC, q_N, q_Z, q_C, q_V);
    end
  endtask

  task automatic test_sub();
    preload(8'd5, 16'h0003);
    preload(8'd6, 16'h0002);
    run_op(LDA, 8'd6, 1'b0);
    run_op(SUB, 8'd5, 1'b0);
    vectors++;
    if ({q_AC, q_N, q_Z, q_C, q_V} !== {16'hFFFF, 4'b1010}) begin
      miscompares++;
      $display("FAIL sub_borrow: AC=%h NZCV=%b%b%b%b required AC=ffff NZCV=1010",
               q_AC, q_N, q_Z, q_C, q_V);
    end
    run_op(LDA, 8'd5, 1'b0);
    run_op(SUB, 8'd5, 1'b0);
    vectors++;
    if ({q_AC, q_Z, q_C} !== {16'h0000, 2'b10}) begin
      miscompares++;
      $display("FAIL sub_zero: AC=%h Z=%b C=%b required AC=0000 Z=1 C=0", q_AC, q_Z, q_C);
    end
    preload(8'd10, 16'h0F0F);
    run_op(LDA, 8'd3, 1'b0);
    run_op(AND_, 8'd10, 1'b0);
    run_op(OR_, 8'd4, 1'b0);
  endtask

  task automatic test_sta_lda();
    preload(8'd7, 16'h1234);
    preload(8'd9, 16'hDEAD);
    run_op(LDA, 8'd7, 1'b0);
    run_op(STA, 8'd9, 1'b0);
    run_op(LDA, 8'd9, 1'b0);
    vectors++;
    if ({q_MEM, q_AC} !== {16'h1234, 16'h1234}) begin
      miscompares++;
      $display("FAIL sta_then_lda: MEM=%h AC=%h required 1234 1234", q_MEM, q_AC);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    preload(8'd20, 16'h00AA);
    preload(8'd21, 16'h0F00);
    run_op(LDA, 8'd20, 1'b1);
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL busy_ignore_extra: %0d stray busy/done cycles required 0", dones);
    end
    run_op(STA, 8'd21, 1'b1);
    run_op(LDA, 8'd20, 1'b0);
    run_op(ADD, 8'd21, 1'b0);
  endtask

  task automatic test_not_nop();
    preload(8'd8, 16'hFFFF);
    run_op(LDA, 8'd8, 1'b0);
    run_op(NOT_, 8'd8, 1'b0);
    vectors++;
    if ({q_AC, q_N, q_Z, q_C, q_V} !== {16'h0000, 4'b0100}) begin
      miscompares++;
      $display("FAIL not_ffff: AC=%h NZCV=%b%b%b%b required AC=0000 NZCV=0100",
               q_AC, q_N, q_Z, q_C, q_V);
    end
    run_op(NOP, 8'd0, 1'b0);
    run_op(LDA, 8'd4, 1'b0);
    run_op(NOP, 8'd3, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    int dones;
    run_op(LDA, 8'd3, 1'b0);
    start = 1'b1; op = LDA; addr = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;  // now in EXEC
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, q_AC, q_MEM, q_N, q_Z, q_C, q_V} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_mid_exec: busy=%b done=%b AC=%h MEM=%h NZCV=%b%b%b%b required all 0",
               busy, done, q_AC, q_MEM, q_N, q_Z, q_C, q_V);
    end
    m_ac = 16'h0; m_qm = 16'h0;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_abort_done: %0d done/busy cycles after abort required 0", dones);
    end
    run_op(ADD, 8'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sta_lda();
    test_busy_ignore();
    test_not_nop();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule : tb_unidade_processamento_seq
